// File: rtl/picorv32_rf_multi.sv
// Parametrised multi-read-port register file with write bypass, optional hardwired x0,
// a post-reset clear sequencer, a ready flag and a sticky illegal-write flag.
module picorv32_rf_multi #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 6,
    parameter int DEPTH          = 36,
    parameter int NUM_READ       = 2,
    parameter int READ_LATENCY   = 0,
    parameter int BYPASS         = 1,
    parameter int ZERO_REG0      = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           clear,
    input  logic                           wr,
    input  logic [ADDR_WIDTH-1:0]          wa,
    input  logic [DATA_WIDTH-1:0]          d,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
    output logic [NUM_READ*DATA_WIDTH-1:0] q,
    output logic                           ready,
    output logic                           err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic wa_in_range;
    logic wa_is_zero;
    logic wr_accept;
    logic wr_illegal;

    assign wa_in_range = ({1'b0, wa} < DEPTH_A);
    assign wa_is_zero  = (ZERO_REG0 != 0) && (wa == '0);
    assign wr_accept   = wr && ready_q && wa_in_range && !wa_is_zero;
    assign wr_illegal  = wr && (!ready_q || !wa_in_range);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clear) begin
                    ptr_d = '0;
                end else if (ptr_q == PTR_LAST) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            default: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
        // A clear request wins over an illegal write in the same cycle.
        err_d   = clear ? 1'b0 : (err_q || wr_illegal);
        ready_d = (state_d == ST_RUN);
    end

    // Storage is deliberately not reset; the sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[ptr_q] <= '0;
        end else if (wr_accept) begin
            mem[wa] <= d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ra_sel;
            logic [DATA_WIDTH-1:0] rd_d;

            assign ra_sel = ra[gi*ADDR_WIDTH +: ADDR_WIDTH];

            always_comb begin
                rd_d = '0;
                if (ready_q && ({1'b0, ra_sel} < DEPTH_A) &&
                    !((ZERO_REG0 != 0) && (ra_sel == '0))) begin
                    if ((BYPASS != 0) && wr_accept && (wa == ra_sel)) begin
                        rd_d = d;
                    end else begin
                        rd_d = mem[ra_sel];
                    end
                end
            end

            if (READ_LATENCY == 0) begin : g_comb
                assign q[gi*DATA_WIDTH +: DATA_WIDTH] = rd_d;
            end else begin : g_reg
                logic [DATA_WIDTH-1:0] rd_q;
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        rd_q <= '0;
                    end else begin
                        rd_q <= rd_d;
                    end
                end
                assign q[gi*DATA_WIDTH +: DATA_WIDTH] = rd_q;
            end
        end
    endgenerate

    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_picorv32_rf_multi.sv
// Bench: default-config instance plus a 4-port, registered, no-bypass, 16-bit instance
// sharing write/control stimulus, checked against a behavioural model of the register file.
module tb_picorv32_rf_multi;

    localparam int DEPTH = 36;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear;
    logic        wr;
    logic [5:0]  wa;
    logic [31:0] d;
    logic [11:0] ra;
    logic [63:0] q;
    logic        ready;
    logic        err;

    logic [15:0] d2;
    logic [23:0] ra2;
    logic [63:0] q2;
    logic        ready2;
    logic        err2;

    assign d2 = d[15:0];

    always #5 clk = ~clk;

    picorv32_rf_multi dut (
        .clk(clk), .resetn(resetn), .clear(clear), .wr(wr), .wa(wa), .d(d),
        .ra(ra), .q(q), .ready(ready), .err(err)
    );

    picorv32_rf_multi #(
        .DATA_WIDTH(16), .NUM_READ(4), .READ_LATENCY(1), .BYPASS(0)
    ) dut2 (
        .clk(clk), .resetn(resetn), .clear(clear), .wr(wr), .wa(wa), .d(d2),
        .ra(ra2), .q(q2), .ready(ready2), .err(err2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: register contents, ready/err flags, remaining clear cycles.
    logic [31:0] m_mem [DEPTH];
    bit          m_ready;
    bit          m_err;
    int          m_clear_left;
    logic [15:0] exp_q2 [4];

    logic [31:0] last_q0, last_q1;
    logic [15:0] last_q2 [4];
    logic        last_ready, last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] eff(input logic [5:0] a, input bit byp);
        if (!m_ready || int'(a) >= DEPTH || a == 6'd0) return 32'h0;
        if (byp && wr && int'(wa) < DEPTH && wa != 6'd0 && wa == a) return d;
        return m_mem[a];
    endfunction

    task automatic model_reset();
        m_ready      = 1'b0;
        m_err        = 1'b0;
        m_clear_left = DEPTH;
        for (int i = 0; i < 4; i++) exp_q2[i] = 16'h0;
    endtask

    task automatic model_edge();
        if (m_clear_left > 0) begin
            if (wr && !clear) m_err = 1'b1;
            if (clear) begin
                m_clear_left = DEPTH;
                m_err        = 1'b0;
            end else begin
                m_clear_left--;
                if (m_clear_left == 0) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
                end
            end
        end else if (clear) begin
            m_clear_left = DEPTH;
            m_ready      = 1'b0;
            m_err        = 1'b0;
        end else if (wr) begin
            if (int'(wa) >= DEPTH) m_err = 1'b1;
            else if (wa != 6'd0) m_mem[wa] = d;
        end
    endtask

    // One clock: drive at negedge, check just after, then advance the model at posedge.
    task automatic step(input bit clr, input bit w, input logic [5:0] a, input logic [31:0] dv,
                        input logic [5:0] r0, input logic [5:0] r1, input logic [23:0] r2);
        logic [15:0] nxt [4];
        logic [31:0] tmp;
        @(negedge clk);
        clear = clr; wr = w; wa = a; d = dv; ra = {r1, r0}; ra2 = r2;
        #1;
        last_q0 = q[31:0]; last_q1 = q[63:32]; last_ready = ready; last_err = err;
        chk("ready", {31'h0, ready}, {31'h0, m_ready});
        chk("err", {31'h0, err}, {31'h0, m_err});
        chk("q0", q[31:0], eff(r0, 1'b1));
        chk("q1", q[63:32], eff(r1, 1'b1));
        chk("ready2", {31'h0, ready2}, {31'h0, m_ready});
        chk("err2", {31'h0, err2}, {31'h0, m_err});
        for (int i = 0; i < 4; i++) begin
            last_q2[i] = q2[i*16 +: 16];
            chk($sformatf("q2[%0d]", i), {16'h0, q2[i*16 +: 16]}, {16'h0, exp_q2[i]});
            tmp    = eff(r2[i*6 +: 6], 1'b0);
            nxt[i] = tmp[15:0];
        end
        @(posedge clk);
        model_edge();
        for (int i = 0; i < 4; i++) exp_q2[i] = nxt[i];
    endtask

    task automatic idle(input logic [5:0] r0, input logic [5:0] r1, input logic [23:0] r2);
        step(1'b0, 1'b0, 6'd0, 32'h0, r0, r1, r2);
    endtask

    initial begin
        int lowc;
        logic [5:0] a, r0, r1;
        bit clr, w;

        clear = 0; wr = 0; wa = 0; d = 0; ra = 0; ra2 = 0; resetn = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hx;
        model_reset();

        // Held in reset
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_q", q[31:0] | q[63:32], 32'h0);
        chk("rst_q2", q2[31:0] | q2[63:32], 32'h0);

        @(posedge clk); #2 resetn = 1;
        lowc = 0;
        for (int k = 0; k < 40; k++) begin
            idle(6'(k % DEPTH), 6'(35 - k % DEPTH), {4{6'(k % DEPTH)}});
            if (last_ready === 1'b0) lowc++;
        end
        chk("ready_low_cycles", lowc, 36);
        for (int k = 0; k < DEPTH; k++) idle(6'(k), 6'(35 - k), {4{6'(k)}});

        // Bypass and next-cycle read
        step(1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 6'd5, 6'd0, 24'h0);
        chk("bypass_q0", last_q0, 32'hDEADBEEF);
        idle(6'd0, 6'd5, 24'h0);
        chk("next_q1", last_q1, 32'hDEADBEEF);

        // Hardwired zero register
        step(1'b0, 1'b1, 6'd0, 32'h12345678, 6'd0, 6'd0, 24'h0);
        idle(6'd0, 6'd0, 24'h0);
        chk("reg0_q0", last_q0, 32'h0);
        chk("reg0_err", {31'h0, last_err}, 32'h0);

        // Out-of-range write
        step(1'b0, 1'b1, 6'd40, 32'hCAFEF00D, 6'd0, 6'd0, 24'h0);
        idle(6'd40, 6'd40, 24'h0);
        chk("reg40_err", {31'h0, last_err}, 32'h1);
        chk("reg40_q0", last_q0, 32'h0);

        // Clear pulse, write attempt during CLEAR at cycle 10
        step(1'b1, 1'b0, 6'd0, 32'h0, 6'd0, 6'd0, 24'h0);
        lowc = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, k == 10, 6'd3, 32'hAA, 6'd3, 6'd5, 24'h0);
            if (k == 0) chk("clear_err0", {31'h0, last_err}, 32'h0);
            if (k == 11) chk("clear_err1", {31'h0, last_err}, 32'h1);
            if (last_ready === 1'b0) lowc++;
        end
        chk("clear_low_cycles", lowc, 36);
        idle(6'd3, 6'd5, 24'h0);
        chk("reg3_after_clear", last_q0, 32'h0);

        // Registered, no-bypass instance
        step(1'b0, 1'b1, 6'd7, 32'h0000BEEF, 6'd0, 6'd0, {4{6'd7}});
        idle(6'd7, 6'd7, {4{6'd7}});
        for (int i = 0; i < 4; i++) chk($sformatf("nobyp_old[%0d]", i), {16'h0, last_q2[i]}, 32'h0);
        idle(6'd7, 6'd7, {4{6'd7}});
        for (int i = 0; i < 4; i++) chk($sformatf("nobyp_new[%0d]", i), {16'h0, last_q2[i]}, 32'hBEEF);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            clr = ($urandom_range(0, 99) == 0);
            w   = !clr && ($urandom_range(0, 1) == 1);
            a   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 35));
            r0  = ($urandom_range(0, 2) == 0) ? a : 6'($urandom_range(0, 63));
            r1  = ($urandom_range(0, 2) == 0) ? a : 6'($urandom_range(0, 40));
            step(clr, w, a, $urandom, r0, r1,
                 {6'($urandom_range(0, 40)), 6'($urandom_range(0, 40)), r1, r0});
        end

        // Async reset in RUN with err set and registered data nonzero
        for (int k = 0; k < 40 && !m_ready; k++) idle(6'd0, 6'd0, 24'h0);
        step(1'b0, 1'b1, 6'd9, 32'h1234ABCD, 6'd0, 6'd0, 24'h0);
        step(1'b0, 1'b1, 6'd50, 32'h1, 6'd0, 6'd0, 24'h0);
        idle(6'd9, 6'd9, {4{6'd9}});
        idle(6'd9, 6'd9, {4{6'd9}});
        chk("pre_rst_err", {31'h0, last_err}, 32'h1);
        chk("pre_rst_q2", {16'h0, last_q2[0]}, 32'hABCD);
        #2 resetn = 0;
        #1;
        chk("async_ready", {31'h0, ready}, 32'h0);
        chk("async_err", {31'h0, err}, 32'h0);
        chk("async_q", q[31:0] | q[63:32], 32'h0);
        for (int i = 0; i < 4; i++) chk($sformatf("async_q2[%0d]", i), {16'h0, q2[i*16 +: 16]}, 32'h0);
        model_reset();
        @(posedge clk); @(posedge clk); #2 resetn = 1;
        lowc = 0;
        for (int k = 0; k < 40; k++) begin
            idle(6'd9, 6'd0, {4{6'd9}});
            if (last_ready === 1'b0) lowc++;
        end
        chk("reset2_low_cycles", lowc, 36);
        for (int k = 0; k < DEPTH; k++) idle(6'(k), 6'(35 - k), {4{6'(k)}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/picorv32_rf_multi.md
Name: picorv32_rf_multi

Overview:
- Parametrised successor to the fixed two-read/one-write CPU register file.
- Configurable data width, depth and read-port count; selectable combinational or registered reads.
- Adds write-to-read bypass, optional hardwired-zero register 0, and a post-reset clear sequencer with a ready flag.
- Sticky error flag for illegal writes.
- Sits between the picorv32 decode stage and the ALU/writeback path; drop-in for the fixed register file when NUM_READ=2 and READ_LATENCY=0.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 6, address width of every port.
- DEPTH, 36, number of implemented registers; must be ≤ 2^ADDR_WIDTH.
- NUM_READ, 2, number of read ports (1..4).
- READ_LATENCY, 0, 0 = combinational read, 1 = registered read.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.
- ZERO_REG0, 1, 1 = address 0 always reads 0 and writes to it are dropped.
- CLEAR_ON_RESET, 1, 1 = zero all registers after reset via the clear sequencer.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous request to rerun the clear sequence; pulse.
- wr  in  1  write enable.
- wa  in  ADDR_WIDTH  write address.
- d  in  DATA_WIDTH  write data.
- ra  in  NUM_READ*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- q  out  NUM_READ*DATA_WIDTH  read data; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- ready  out  1  register file usable; writes accepted.
- err  out  1  sticky illegal-write flag.

Behaviour:
- Reset (resetn low, async): FSM→CLEAR if CLEAR_ON_RESET else RUN; clear pointer=0; ready=0; err=0; registered q (READ_LATENCY=1) = 0.
- Array contents are not reset; they are zeroed by the sequencer.
- FSM states:
  - CLEAR: each cycle writes 0 to array[ptr], ptr++. At ptr=DEPTH-1, next state is RUN.
  - RUN: ready=1.
- CLEAR takes exactly DEPTH cycles. ready rises on the first clock edge after the last clear write; ready is registered.
- clear=1 in RUN: next cycle enters CLEAR with ptr=0, ready=0, err=0.
- clear=1 in CLEAR: ptr restarts at 0.
- Accepted write: wr & ready & wa<DEPTH & !(ZERO_REG0 & wa==0). The array updates at the clock edge.
- Illegal write: wr & (!ready | wa≥DEPTH). Write dropped; err←1, held until reset or clear.
- A write to address 0 with ZERO_REG0=1 is dropped silently, not an error.
- Read port i, effective value:
  - 0 if !ready;
  - else 0 if ra_i≥DEPTH or (ZERO_REG0 & ra_i==0);
  - else d if BYPASS & accepted write & wa==ra_i;
  - else array[ra_i].
- READ_LATENCY=0: q_i = effective value, combinational.
- READ_LATENCY=1: q_i registered from the effective value each cycle; 1-cycle latency, no enable.
- BYPASS=0, latency 0: same-address read returns the old value. The new value is visible the next cycle.
- Simultaneous reads on several ports of the same address return identical data.
- Reset asserted mid-CLEAR or mid-RUN: immediate return to reset state; contents indeterminate until the next clear completes.

Test Plan:
- Reset, defaults (DEPTH=36): ready low for exactly 36 cycles after resetn rises, then high; every register 0..35 reads 0x00000000 on both ports.
- Defaults: write 0xDEADBEEF to reg 5. Same cycle, ra0=5 → q0=0xDEADBEEF (bypass). Next cycle, ra1=5 → q1=0xDEADBEEF.
- ZERO_REG0: write 0x12345678 to reg 0 → reads 0, err stays 0. Write to reg 40 → dropped, err=1, reg 40 reads 0. Pulse clear → err=0, ready low for 36 cycles.
- Write attempt during CLEAR (cycle 10 after reset) to reg 3 with 0xAA → err=1; reg 3 reads 0 after ready.
- NUM_READ=4, READ_LATENCY=1, BYPASS=0, DATA_WIDTH=16: write 0xBEEF to reg 7, all ra=7 same cycle. The q registered at that edge is 0 on all four ports. One cycle later all four ports show 0xBEEF.
- Assert resetn low mid-RUN after writes → ready=0, err=0, registered q=0 immediately (async). Then 36-cycle clear, all registers read 0.
